// File: rtl/sum_acc_pkg.sv
// Shared types and widths for the sum_accumulator block.
package sum_acc_pkg;

    // Operand width: {Cout, S} from the 4-bit adder stage.
    localparam int OPND_W = 5;
    // Count width: holds values up to the largest batch size (16).
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sum_acc_ctrl.sv
// Batch controller for sum_accumulator: owns the IDLE/ACC/DONE FSM and the
// per-batch accept counter, and tells the datapath when to add or clear.
module sum_acc_ctrl
    import sum_acc_pkg::*;
#(
    parameter int BATCH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_in_valid,
    input  logic             i_out_ready,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic             o_accept,
    output logic             o_clear,
    output logic [CNT_W-1:0] o_count
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_last;
    logic             w_handshake;

    // clr outranks both a new accept and the downstream handshake.
    assign o_accept    = i_in_valid & o_in_ready & ~i_clr;
    assign w_handshake = o_out_valid & i_out_ready & ~i_clr;
    assign o_clear     = i_clr | w_handshake;
    // The accept arriving while the count is BATCH-1 closes the batch.
    assign w_last      = (r_count == CNT_W'(BATCH - 1));
    assign o_count     = r_count;

    // State register with synchronous reset and abort.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (i_clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs, decoded from the current state.
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (o_accept) begin
                    w_next = w_last ? DONE : ACC;
                end
            end
            ACC: begin
                o_in_ready = 1'b1;
                if (o_accept && w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                o_out_valid = 1'b1;
                if (w_handshake) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Accept counter: cleared on abort or on batch hand-off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (o_clear) begin
            r_count <= '0;
        end else if (o_accept) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: adds BATCH unsigned {Cout,S} results from a 4-bit adder
// stage into an ACC_W-bit total, flags overflow, and presents the total
// with a valid/ready handshake.
// Build option: define SUM_ACC_SATURATE_EN to clamp acc at its maximum on
// overflow; otherwise acc wraps modulo 2^ACC_W.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int ACC_W = 8,
    parameter int BATCH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       S,
    input  logic             Cout,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;
    logic              w_accept;
    logic              w_clear;
    logic [OPND_W-1:0] w_opnd;
    logic [ACC_W:0]    w_sum;
    logic              w_carry;
    logic [ACC_W-1:0]  w_acc_next;

    sum_acc_ctrl #(
        .BATCH (BATCH)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (clr),
        .i_in_valid  (in_valid),
        .i_out_ready (out_ready),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_accept    (w_accept),
        .o_clear     (w_clear),
        .o_count     (count)
    );

    // One extra bit on the adder exposes the overflow as its carry-out.
    assign w_opnd  = {Cout, S};
    assign w_sum   = {1'b0, r_acc} + (ACC_W + 1)'(w_opnd);
    assign w_carry = w_sum[ACC_W];

`ifdef SUM_ACC_SATURATE_EN
    // Once pinned at all-ones, any further add carries again, so it stays put.
    assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    // Running total: cleared on reset, abort or hand-off, updated on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_clear) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
        end
    end

    // Sticky overflow flag for the current batch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_clear) begin
            r_ovf <= 1'b0;
        end else if (w_accept && w_carry) begin
            r_ovf <= 1'b1;
        end
    end

    assign acc = r_acc;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: two instances (BATCH=4 and BATCH=16, ACC_W=8)
// share one stimulus stream and are compared against an integer model that
// keeps the exact batch sum and derives acc/ovf from it.
module tb_sum_accumulator;

    localparam int ACC_W = 8;
    localparam int MAXV  = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] S = '0;
    logic       Cout = 1'b0;

    logic [1:0]            in_ready_w;
    logic [1:0]            out_valid_w;
    logic [1:0]            ovf_w;
    logic [1:0][ACC_W-1:0] acc_w;
    logic [1:0][4:0]       count_w;

    sum_accumulator #(.ACC_W(ACC_W), .BATCH(4)) dut_b4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_ready(in_ready_w[0]), .S(S), .Cout(Cout), .acc(acc_w[0]),
        .count(count_w[0]), .ovf(ovf_w[0]), .out_valid(out_valid_w[0]),
        .out_ready(out_ready)
    );

    sum_accumulator #(.ACC_W(ACC_W), .BATCH(16)) dut_b16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_ready(in_ready_w[1]), .S(S), .Cout(Cout), .acc(acc_w[1]),
        .count(count_w[1]), .ovf(ovf_w[1]), .out_valid(out_valid_w[1]),
        .out_ready(out_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: exact (unbounded) batch sum, accept count, done flag.
    int m_sum [2];
    int m_cnt [2];
    bit m_done[2];
    bit m_known = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int batch_of(input int d);
        return (d == 0) ? 4 : 16;
    endfunction

    function automatic int exp_acc(input int d);
`ifdef SUM_ACC_SATURATE_EN
        return (m_sum[d] > MAXV) ? MAXV : m_sum[d];
`else
        return m_sum[d] % (MAXV + 1);
`endif
    endfunction

    function automatic void model_clear(input int d);
        m_sum[d]  = 0;
        m_cnt[d]  = 0;
        m_done[d] = 1'b0;
    endfunction

    // One clock: drive at negedge, check ready/valid before the edge,
    // advance the model at posedge, check all outputs #1 after it.
    task automatic tick(input bit rn, input bit c, input bit v, input int op, input bit ordy);
        @(negedge clk);
        rst_n     = rn;
        clr       = c;
        in_valid  = v;
        {Cout, S} = 5'(op);
        out_ready = ordy;
        #1;
        if (m_known) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d_pre_in_ready", d), 32'(in_ready_w[d]), 32'(!m_done[d]));
                check($sformatf("d%0d_pre_out_valid", d), 32'(out_valid_w[d]), 32'(m_done[d]));
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rn || c) begin
                model_clear(d);
            end else if (m_done[d]) begin
                if (ordy) model_clear(d);
            end else if (v) begin
                m_sum[d] += op;
                m_cnt[d] += 1;
                if (m_cnt[d] == batch_of(d)) m_done[d] = 1'b1;
            end
        end
        if (!rn) m_known = 1'b1;
        #1;
        if (m_known) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d_acc", d), 32'(acc_w[d]), 32'(exp_acc(d)));
                check($sformatf("d%0d_count", d), 32'(count_w[d]), 32'(m_cnt[d]));
                check($sformatf("d%0d_ovf", d), 32'(ovf_w[d]), 32'(m_sum[d] > MAXV));
                check($sformatf("d%0d_out_valid", d), 32'(out_valid_w[d]), 32'(m_done[d]));
                check($sformatf("d%0d_in_ready", d), 32'(in_ready_w[d]), 32'(!m_done[d]));
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) model_clear(d);

        // Reset held for two cycles.
        tick(1'b0, 1'b0, 1'b0, 0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("rst_acc", 32'(acc_w[0]), 32'd0);
        check("rst_in_ready", 32'(in_ready_w[0]), 32'd1);
        check("rst_out_valid", 32'(out_valid_w[0]), 32'd0);

        // BATCH=4 back-to-back batch, then a stalled hand-off with input held.
        tick(1'b1, 1'b0, 1'b1, 5, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 19, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 15, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 31, 1'b0);
        check("b4_total", 32'(acc_w[0]), 32'd70);
        check("b4_done", 32'(out_valid_w[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b1, 9, 1'b0);
            check("b4_hold_acc", 32'(acc_w[0]), 32'd70);
            check("b4_hold_count", 32'(count_w[0]), 32'd4);
            check("b4_hold_in_ready", 32'(in_ready_w[0]), 32'd0);
        end
        tick(1'b1, 1'b0, 1'b0, 0, 1'b1);
        check("b4_handoff_acc", 32'(acc_w[0]), 32'd0);
        check("b4_handoff_valid", 32'(out_valid_w[0]), 32'd0);

        // Overflow run on BATCH=16: operand 31 every cycle.
        tick(1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            tick(1'b1, 1'b0, 1'b1, 31, 1'b0);
            if (i == 8) begin
                check("b16_acc8", 32'(acc_w[1]), 32'd248);
                check("b16_ovf8", 32'(ovf_w[1]), 32'd0);
            end
            if (i == 9) check("b16_ovf9", 32'(ovf_w[1]), 32'd1);
        end
`ifdef SUM_ACC_SATURATE_EN
        check("b16_final", 32'(acc_w[1]), 32'd255);
`else
        check("b16_final", 32'(acc_w[1]), 32'd240);
`endif
        check("b16_done", 32'(out_valid_w[1]), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 0, 1'b1);

        // Abort after two accepts with a valid input present, then restart.
        tick(1'b1, 1'b0, 1'b1, 3, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 7, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 9, 1'b0);
        check("clr_acc", 32'(acc_w[0]), 32'd0);
        check("clr_count", 32'(count_w[0]), 32'd0);
        for (int i = 1; i <= 4; i++) tick(1'b1, 1'b0, 1'b1, i, 1'b0);
        check("restart_acc", 32'(acc_w[0]), 32'd10);
        tick(1'b1, 1'b0, 1'b0, 0, 1'b1);

        // Reset mid-batch, then reset while DONE.
        tick(1'b1, 1'b0, 1'b1, 20, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 21, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 22, 1'b0);
        check("rst_mid_count", 32'(count_w[0]), 32'd0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 30, 1'b0);
        check("pre_rst_done", 32'(out_valid_w[0]), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 0, 1'b1);
        check("rst_done_valid", 32'(out_valid_w[0]), 32'd0);
        check("rst_done_in_ready", 32'(in_ready_w[0]), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            tick(($urandom_range(99) >= 2), ($urandom_range(99) < 3),
                 ($urandom_range(99) < 75), int'($urandom_range(31)),
                 ($urandom_range(99) < 40));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Clock and reset SHALL be one clock; reset is synchronous and active-low, with ports named clk and rst_n.
REQ-002 Parameter ACC_W, default 8, SHALL set the accumulator width; legal range is 6..16.
REQ-003 Parameter BATCH, default 4, SHALL set the number of adder results per batch; legal range is 1..16.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 clr  input  1  synchronous batch abort.
REQ-007 in_valid  input  1  an upstream adder result is present.
REQ-008 in_ready  output  1  the block can accept a result this cycle.
REQ-009 S  input  4  sum bits from the 4-bit adder stage.
REQ-010 Cout  input  1  carry-out (C[4]) from the 4-bit adder stage.
REQ-011 acc  output  ACC_W  running total, registered.
REQ-012 count  output  5  results accepted in the current batch.
REQ-013 ovf  output  1  sticky overflow flag for the current batch.
REQ-014 out_valid  output  1  batch total on acc is final.
REQ-015 out_ready  input  1  downstream consumes the batch total.

Function
REQ-016 The operand SHALL be the 5-bit unsigned value {Cout,S}, range 0..31, zero-extended to ACC_W.
REQ-017 An accept SHALL occur in a cycle where in_valid and in_ready are both 1.
REQ-018 The FSM SHALL have three states: IDLE, ACC and DONE.
REQ-019 In IDLE: in_ready=1 and out_valid=0; an accept SHALL move the FSM to ACC, or to DONE when BATCH=1.
REQ-020 In ACC: in_ready=1; the accept that makes count equal BATCH SHALL move the FSM to DONE.
REQ-021 In DONE: in_ready=0 and out_valid=1; acc, count and ovf SHALL hold until out_valid and out_ready are both 1.
REQ-022 On handshake in DONE, the next cycle SHALL be IDLE with acc=0, count=0, ovf=0; no input SHALL be accepted in the handshake cycle.
REQ-023 Latency: acc and count SHALL update on the clock edge that ends the accept cycle.
REQ-024 Latency: out_valid SHALL rise on the edge ending the BATCH-th accept.
REQ-025 Overflow: if an accept produces a sum above 2^ACC_W-1, ovf SHALL set on that edge and stay set until the batch ends or is cleared.
REQ-026 Overflow: acc behaviour SHALL follow REQ-031/REQ-032.
REQ-027 clr=1 in any state SHALL produce, next cycle: IDLE, acc=0, count=0, ovf=0, out_valid=0.
REQ-028 clr SHALL win over a simultaneous accept or handshake; the input is not accepted.
REQ-029 in_valid with in_ready=0 SHALL have no effect; upstream holds its data.

Reset
REQ-030 rst_n=0 at a clock edge, in any state including mid-batch or DONE, SHALL give: IDLE, acc=0, count=0, ovf=0, out_valid=0, in_ready=1; rst_n has priority over clr.

Configuration
REQ-031 With SUM_ACC_SATURATE_EN defined, an overflowing accept SHALL clamp acc to 2^ACC_W-1, and later accepts in the batch SHALL keep it there.
REQ-032 Without SUM_ACC_SATURATE_EN, acc SHALL wrap modulo 2^ACC_W; ovf behaviour is identical in both builds.

Structure
REQ-033 Package sum_acc_pkg SHALL hold the state enum (IDLE/ACC/DONE), OPND_W=5 and CNT_W=5.
REQ-034 One sub-module, sum_acc_ctrl, SHALL hold the FSM and count; the acc datapath and overflow logic SHALL stay in sum_accumulator.

Verification
REQ-035 Reset: hold rst_n=0 for 2 cycles -> acc=0, count=0, ovf=0, out_valid=0, in_ready=1.
REQ-036 BATCH=4: accept {Cout,S}=5, 19, 15, 31 back-to-back -> acc=70, out_valid=1 on the edge after the 4th accept; hold out_ready=0 for 3 cycles -> acc holds 70; pulse out_ready -> acc=0, IDLE.
REQ-037 Held input in DONE: in_valid=1 throughout DONE -> in_ready=0 and acc/count unchanged.
REQ-038 Overflow, BATCH=16, ACC_W=8, operand 31 every cycle: after the 8th accept acc=248; the 9th accept sets ovf; final acc=240 without the macro, 255 with SUM_ACC_SATURATE_EN.
REQ-039 Abort: after 2 accepts, clr=1 with in_valid=1 -> next cycle acc=0, count=0, the input is not accepted; the batch restarts cleanly.
REQ-040 Mid-batch and DONE reset: rst_n=0 in ACC and again in DONE -> REQ-030 values on the next cycle.
